// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// master: program loader / memory side; slave: the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [20:0]       in_imm;
    logic              in_last;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic micro-ops into Xenyx-4 words and streams them into instruction memory.
// Define ENC_RANGE_CHECK_EN to add immediate range checking and the err_range output.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            err_illegal,
    output logic            err_ovf,
`ifdef ENC_RANGE_CHECK_EN
    output logic            err_range,
`endif
    output logic [ADDR_W:0] count
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JAL  = 4'd9;
    localparam logic [3:0] OP_JALR = 4'd10;
    localparam logic [3:0] OP_PRNT = 4'd11;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       enc_word;
    logic              op_legal;
    logic              imm_bad;
    logic              accept;
    logic              wr_done;
    logic              room;

    logic [4:0]  rd, rs1, rs2;
    logic [20:0] imm;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign imm = bus.in_imm;

    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        case (bus.in_op)
            OP_ADD:  enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_SUB:  enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_AND:  enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            OP_OR:   enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            OP_XOR:  enc_word = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
            OP_ADDI: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            OP_LW:   enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_SW:   enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_BEQ:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11],
                                 7'b1100011};
            OP_JAL:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            OP_JALR: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            OP_PRNT: enc_word = {12'b0, rs1, 3'b000, 5'b0, 7'b1111111};
            default: op_legal = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic range_q, range_d;

    always_comb begin
        imm_bad = 1'b0;
        case (bus.in_op)
            OP_ADDI, OP_LW, OP_SW, OP_JALR: imm_bad = imm[20:11] != {10{imm[11]}};
            OP_BEQ:  imm_bad = (imm[20:12] != {9{imm[12]}}) || imm[0];
            OP_JAL:  imm_bad = imm[0];
            default: imm_bad = 1'b0;
        endcase
    end
    assign err_range = range_q;
`else
    assign imm_bad = 1'b0;
`endif

    assign bus.in_ready = (state_q == StLoad) && (!wr_en_q || bus.wr_ready) && !ovf_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_done      = wr_en_q && bus.wr_ready;
    // The word in flight already claims a slot even if it retires this cycle.
    assign room         = (count_q + (ADDR_W+1)'(wr_en_q)) != DEPTH_C;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        done_d    = done_q;
        ill_d     = ill_q;
        ovf_d     = ovf_q;
`ifdef ENC_RANGE_CHECK_EN
        range_d   = range_q;
`endif
        if (start) begin
            state_d   = StLoad;
            wr_en_d   = 1'b0;
            wr_data_d = '0;
            wr_addr_d = BASE;
            count_d   = '0;
            done_d    = 1'b0;
            ill_d     = 1'b0;
            ovf_d     = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
            range_d   = 1'b0;
`endif
        end else begin
            if (wr_done) begin
                wr_en_d   = 1'b0;
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                count_d   = count_q + (ADDR_W+1)'(1);
            end
            if (accept) begin
                if (!op_legal) begin
                    ill_d = 1'b1;
                end else if (imm_bad) begin
`ifdef ENC_RANGE_CHECK_EN
                    range_d = 1'b1;
`endif
                end else if (!room) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = enc_word;
                end
                if (bus.in_last) state_d = StDrain;
            end
            if (state_q == StDrain && (!wr_en_q || bus.wr_ready)) begin
                state_d = StDone;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= BASE;
            count_q   <= '0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
            range_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ill_q     <= ill_d;
            ovf_q     <= ovf_d;
`ifdef ENC_RANGE_CHECK_EN
            range_q   <= range_d;
`endif
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_addr = wr_addr_q;
    assign busy        = (state_q == StLoad);
    assign done        = done_q;
    assign err_illegal = ill_q;
    assign err_ovf     = ovf_q;
    assign count       = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, stalls, illegal ops, overflow, async reset.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, err_illegal, err_ovf;
    logic busy2, done2, err_illegal2, err_ovf2;
    logic [8:0] count, count2;
`ifdef ENC_RANGE_CHECK_EN
    logic err_range, err_range2;
`endif
    int n_cmp = 0;
    int n_err = 0;

    instr_encoder_if #(.ADDR_W(8)) bus ();
    instr_encoder_if #(.ADDR_W(8)) bus2 ();

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_ovf(err_ovf),
`ifdef ENC_RANGE_CHECK_EN
        .err_range(err_range),
`endif
        .count(count)
    );

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2), .busy(busy2), .done(done2),
        .err_illegal(err_illegal2), .err_ovf(err_ovf2),
`ifdef ENC_RANGE_CHECK_EN
        .err_range(err_range2),
`endif
        .count(count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [20:0] imm, input logic last);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_last  = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_imm = '0; bus.in_last = 1'b0; bus.wr_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_op = 4'd0; bus2.in_rd = 5'd1; bus2.in_rs1 = 5'd2;
        bus2.in_rs2 = 5'd3; bus2.in_imm = '0; bus2.in_last = 1'b0; bus2.wr_ready = 1'b1;
        tick();
        tick();
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", {28'd0, busy, done, err_illegal, err_ovf}, 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Single ADD with in_last
        pulse_start();
        check("busy_load", 32'(busy), 32'd1);
        req(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("add_wr_en", 32'(bus.wr_en), 32'd1);
        check("add_addr", 32'(bus.wr_addr), 32'd0);
        check("add_data", bus.wr_data, 32'h002081B3);
        tick();
        check("add_done", 32'(done), 32'd1);
        check("add_count", 32'(count), 32'd1);

        // SUB then ADDI back-to-back
        pulse_start();
        check("start_clr_done", 32'(done), 32'd0);
        req(4'd1, 5'd5, 5'd6, 5'd7, 21'd0, 1'b0);
        tick();
        check("sub_data", bus.wr_data, 32'h407302B3);
        check("sub_addr", 32'(bus.wr_addr), 32'd0);
        req(4'd5, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 1'b1);
        #1 check("b2b_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("addi_wr_en", 32'(bus.wr_en), 32'd1);
        check("addi_data", bus.wr_data, 32'hFFF00093);
        check("addi_addr", 32'(bus.wr_addr), 32'd1);
        check("b2b_count", 32'(count), 32'd1);
        tick();
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_count2", 32'(count), 32'd2);

        // SW under a 3-cycle write stall, then BEQ/JAL/PRINT
        pulse_start();
        bus.wr_ready = 1'b0;
        req(4'd7, 5'd0, 5'd2, 5'd8, 21'd20, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sw_data", bus.wr_data, 32'h00812A23);
            check("sw_hold_en", 32'(bus.wr_en), 32'd1);
            check("sw_hold_addr", 32'(bus.wr_addr), 32'd0);
            check("sw_stall_rdy", 32'(bus.in_ready), 32'd0);
            check("sw_stall_cnt", 32'(count), 32'd0);
            if (i < 2) tick();
        end
        bus.wr_ready = 1'b1;
        #1 check("sw_rdy_back", 32'(bus.in_ready), 32'd1);
        tick();
        check("sw_count", 32'(count), 32'd1);
        check("sw_addr_inc", 32'(bus.wr_addr), 32'd1);
        check("sw_wr_en_off", 32'(bus.wr_en), 32'd0);
        req(4'd8, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0);
        tick();
        check("beq_data", bus.wr_data, 32'h00208463);
        check("beq_addr", 32'(bus.wr_addr), 32'd1);
        req(4'd9, 5'd1, 5'd0, 5'd0, 21'd16, 1'b0);
        tick();
        check("jal_data", bus.wr_data, 32'h010000EF);
        check("jal_addr", 32'(bus.wr_addr), 32'd2);
        req(4'd11, 5'd0, 5'd4, 5'd0, 21'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("print_data", bus.wr_data, 32'h0002007F);
        check("print_addr", 32'(bus.wr_addr), 32'd3);
        tick();
        check("prog_done", 32'(done), 32'd1);
        check("prog_count", 32'(count), 32'd4);

        // Illegal op
        pulse_start();
        req(4'd13, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0);
        tick();
        check("ill_wr_en", 32'(bus.wr_en), 32'd0);
        check("ill_flag", 32'(err_illegal), 32'd1);
        check("ill_count", 32'(count), 32'd0);
        req(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("ill_next_addr", 32'(bus.wr_addr), 32'd0);
        check("ill_next_data", bus.wr_data, 32'h002081B3);
        tick();
        check("ill_sticky", 32'(err_illegal), 32'd1);
        check("ill_done", 32'(done), 32'd1);
        pulse_start();
        check("ill_cleared", 32'(err_illegal), 32'd0);

        // Overflow on the DEPTH=2 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("ovf_flag", 32'(err_ovf2), 32'd1);
        check("ovf_count", 32'(count2), 32'd2);
        check("ovf_addr", 32'(bus2.wr_addr), 32'd2);
        check("ovf_wr_en", 32'(bus2.wr_en), 32'd0);
        check("ovf_ready", 32'(bus2.in_ready), 32'd0);
        tick();
        check("ovf_ready_held", 32'(bus2.in_ready), 32'd0);
        check("ovf_count_held", 32'(count2), 32'd2);
        bus2.in_valid = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("ovf_clr", 32'(err_ovf2), 32'd0);
        check("ovf_clr_ready", 32'(bus2.in_ready), 32'd1);
        check("ovf_clr_count", 32'(count2), 32'd0);

        // Async reset during a stalled write
        bus.wr_ready = 1'b0;
        req(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_wr_en", 32'(bus.wr_en), 32'd0);
        check("arst_wr_data", bus.wr_data, 32'd0);
        check("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        pulse_start();
        req(4'd5, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_addr", 32'(bus.wr_addr), 32'd0);
        check("post_rst_data", bus.wr_data, 32'h00500093);
        tick();
        check("post_rst_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction decoder. Accepts symbolic micro-op requests (operation, register indices, immediate) over a valid/ready handshake and packs them into 32-bit Xenyx-4 instruction words.
- Writes each packed word sequentially into instruction memory through a registered write port with a word-address counter.
- Used by the program loader and self-test logic to build programs for each core without an external assembler.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, number of writable words; the last legal address is BASE_ADDR+DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new program at BASE_ADDR and clears status.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 JAL, 10 JALR, 11 PRINT; 12-15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  21  signed immediate / byte offset.
- in_last  in  1  marks the final instruction of the program.
- wr_en  out  1  instruction-memory write valid.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- busy  out  1  high in the LOAD state.
- done  out  1  sticky; program complete.
- err_illegal  out  1  sticky; an illegal op was received.
- err_ovf  out  1  sticky; a request would exceed DEPTH.
- count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset values: all outputs 0, count 0, wr_addr BASE_ADDR, state IDLE.
- States:
  - IDLE → LOAD on start.
  - LOAD → DRAIN when a request with in_last is accepted.
  - DRAIN → DONE when the output register empties.
  - DONE → LOAD on start.
  - start in LOAD or DRAIN aborts: clears the output register, address, count and flags, then goes to LOAD.
- in_ready = (state==LOAD) && (!wr_en || wr_ready) && !err_ovf.
- Accept = in_valid && in_ready. One-cycle latency: the word appears on wr_data/wr_en the cycle after accept.
- wr_data, wr_addr and wr_en are held stable while wr_en && !wr_ready.
- Write completes when wr_en && wr_ready: wr_addr+1 and count+1. A simultaneous accept loads the next word with no bubble, giving a throughput of 1 word per cycle.
- Encoding (field layout funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] opcode[6:0]):
  - R-type, opcode 0110011, funct3/funct7:
    - ADD 000/0000000
    - SUB 000/0100000
    - AND 111/0000000
    - OR 110/0000000
    - XOR 100/0000000
  - ADDI: opcode 0010011, f3 000, imm[11:0]→[31:20].
  - LW: opcode 0000011, f3 010, I-format.
  - SW: opcode 0100011, f3 010, imm[11:5]→[31:25], imm[4:0]→[11:7].
  - BEQ: opcode 1100011, f3 000, imm[12|10:5]→[31:25], imm[4:1|11]→[11:7]. imm[0] is ignored.
  - JAL: opcode 1101111, imm[20|10:1|11|19:12]→[31:12].
  - JALR: opcode 1100111, f3 000, I-format.
  - PRINT: opcode 1111111, rs1 in [19:15], all other bits 0.
  - Unused register fields are 0.
- Immediates are truncated to field width; upper bits are ignored.
- Illegal op (12-15): consumed (in_ready honoured), no word written, err_illegal set.
- Overflow: a request accepted while count + pending == DEPTH sets err_ovf instead of writing. in_ready then stays 0 until start; a pending write still drains.
- in_last on an illegal or overflowing request still moves the FSM to DRAIN.
- done asserts on entry to DONE. busy = (state==LOAD).
- Asynchronous reset mid-write drops the pending word immediately.

Optional Feature:
- ENC_RANGE_CHECK_EN defined:
  - Each immediate must sign-fit its field: I/S 12 bits, B 13 bits with even value, J 21 bits with even value.
  - A violation sets sticky err_range (extra 1-bit output, reset 0) and suppresses the write, handled like an illegal op.
- Not defined: no err_range port; immediates are silently truncated.

Test Plan:
- start; ADD rd=3 rs1=1 rs2=2, in_last=1 → next cycle wr_en=1, wr_addr=0x00, wr_data=0x002081B3; then done=1, count=1.
- SUB rd=5 rs1=6 rs2=7, then ADDI rd=1 rs1=0 imm=-1, no stalls → 0x407302B3 @0, 0xFFF00093 @1, back-to-back in consecutive cycles.
- SW rs1=2 rs2=8 imm=20 with wr_ready=0 for 3 cycles → wr_data=0x00812A23 held stable, in_ready=0; the write completes on the first wr_ready=1.
- BEQ rs1=1 rs2=2 imm=8 → 0x00208463; JAL rd=1 imm=16 → 0x010000EF; PRINT rs1=4 → 0x0002007F.
- in_op=13 → no wr_en, err_illegal=1, count unchanged; DEPTH=2 with 3 requests → third sets err_ovf, in_ready=0 until start.
- rst asserted while wr_en=1 and wr_ready=0 → all outputs 0 the same cycle; the next start writes at BASE_ADDR.
